// File: rtl/seqsum_pkg.sv
// seqsum_pkg: shared state encoding and width helpers for the sequential term accumulator
package seqsum_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  function automatic int sum_width(input int n, input int terms);
    return n + $clog2(terms);
  endfunction
  function automatic int cnt_width(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/seq_sum200_sum_lanes.sv
// sum_lanes: combinational reduction of LANES N-bit terms to N+$clog2(LANES) bits
module sum_lanes #(
  parameter int N = 4,
  parameter int LANES = 8,
  localparam int W = N + $clog2(LANES)
) (
  input  logic [N-1:0] terms [LANES],
  output logic [W-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + W'(terms[i]);
  end
endmodule

// File: rtl/seq_sum200.sv
// seq_sum200: streams LANES terms per beat and returns the NUM_TERMS frame sum; SEQSUM_LAST_CHECK_EN adds in_last/proto_err framing check
module seq_sum200 import seqsum_pkg::*; #(
  parameter int N = 4,
  parameter int NUM_TERMS = 200,
  parameter int LANES = 8,
  localparam int BEATS = NUM_TERMS / LANES,
  localparam int SUM_W = sum_width(N, NUM_TERMS),
  localparam int LANE_W = N + $clog2(LANES),
  localparam int CNT_W = cnt_width(BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_terms [LANES],
`ifdef SEQSUM_LAST_CHECK_EN
  input  logic             in_last,
  output logic             proto_err,
`endif
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [SUM_W-1:0] sum_out
);
  state_t state, state_n;
  logic [CNT_W-1:0] beat_cnt;
  logic [SUM_W-1:0] acc, acc_n;
  logic [LANE_W-1:0] lane_sum;
  logic fire, last_beat;
  sum_lanes #(.N(N), .LANES(LANES)) u_lanes (.terms(in_terms), .sum(lane_sum));
  assign fire = in_valid && in_ready;
  assign last_beat = beat_cnt == CNT_W'(BEATS - 1);
  assign acc_n = acc + SUM_W'(lane_sum);
  assign sum_valid = state == HOLD;
  always_comb
    state_n = state == ACCUM ? (fire && last_beat ? HOLD : ACCUM) : (sum_ready ? ACCUM : HOLD);
  // in_ready is registered from the next state so it is low throughout reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ACCUM;
      in_ready <= 1'b0;
      beat_cnt <= '0;
      acc <= '0;
      sum_out <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n == ACCUM;
      if (fire) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
        acc <= last_beat ? '0 : acc_n;
        if (last_beat) sum_out <= acc_n;
      end
    end
`ifdef SEQSUM_LAST_CHECK_EN
  // framing stays count-based; a misplaced in_last only raises the sticky flag
  always_ff @(posedge clk or posedge rst)
    if (rst) proto_err <= 1'b0;
    else if (fire && (in_last != last_beat)) proto_err <= 1'b1;
`endif
endmodule
